// File: rtl/rd_data_xbar_nxm.sv
// N-input x M-output read-data crossbar: per-output round-robin, packet lock on LAST, drop of out-of-range beats.
// Optional macro RDXBAR_OUT_SLICE_EN adds a 2-entry skid slice per output (1-cycle latency).
module rd_data_xbar_nxm #(
  parameter int DW = 13,
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int AW = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic [N-1:0]    iVld,
  input  logic [N*DW-1:0] iPld,
  input  logic [N*AW-1:0] iDst,
  output logic [N-1:0]    iRdy,
  output logic [M-1:0]    oVld,
  output logic [M*DW-1:0] oPld,
  output logic [M*SW-1:0] oSrc,
  input  logic [M-1:0]    oRdy,
  output logic          oErr
);

  // Handshake: a beat moves on a rising iClk edge where Vld && Rdy; Vld never waits on Rdy.
  logic [SW-1:0] ptr   [M];
  logic [SW-1:0] owner [M];
  logic [SW-1:0] gnt   [M];
  logic [DW-1:0] aPld  [M];
  logic [M-1:0]  lock;
  logic [M-1:0]  gHas;
  logic [M-1:0]  aVld;
  logic [M-1:0]  aRdy;
  logic          errHit;

  always_comb begin : arbiter
    logic found;
    for (int j = 0; j < M; j++) begin
      found   = 1'b0;
      gnt[j]  = '0;
      gHas[j] = 1'b0;
      aVld[j] = 1'b0;
      aPld[j] = '0;
      if (lock[j]) begin
        gnt[j]  = owner[j];
        gHas[j] = 1'b1;
      end else begin
        // Inputs above the pointer first, then wrap to the lowest requester.
        for (int i = 0; i < N; i++) begin
          if (!found && iVld[i] && iDst[i*AW +: AW] == AW'(j) && SW'(i) > ptr[j]) begin
            found  = 1'b1;
            gnt[j] = SW'(i);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (!found && iVld[i] && iDst[i*AW +: AW] == AW'(j)) begin
            found  = 1'b1;
            gnt[j] = SW'(i);
          end
        end
        gHas[j] = found;
      end
      gHas[j] = gHas[j] && iRst_n;
      for (int i = 0; i < N; i++) begin
        if (gHas[j] && gnt[j] == SW'(i)) begin
          aVld[j] = iVld[i] && iDst[i*AW +: AW] == AW'(j);
          aPld[j] = iPld[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    iRdy   = '0;
    errHit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(iDst[i*AW +: AW]) >= M) begin
        iRdy[i] = 1'b1;
        if (iVld[i]) errHit = 1'b1;
      end
      for (int j = 0; j < M; j++) begin
        if (iDst[i*AW +: AW] == AW'(j) && gHas[j] && gnt[j] == SW'(i) && aRdy[j])
          iRdy[i] = 1'b1;
      end
      iRdy[i] = iRdy[i] && iRst_n;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int j = 0; j < M; j++) begin
        ptr[j]   <= SW'(N-1);
        owner[j] <= '0;
      end
      lock <= '0;
      oErr <= 1'b0;
    end else begin
      for (int j = 0; j < M; j++) begin
        if (aVld[j]) begin
          // Stalled or mid-packet beats pin the owner; LAST acceptance releases and advances.
          if (aRdy[j] && aPld[j][DW-1]) begin
            lock[j] <= 1'b0;
            ptr[j]  <= gnt[j];
          end else begin
            lock[j]  <= 1'b1;
            owner[j] <= gnt[j];
          end
        end
      end
      if (errHit) oErr <= 1'b1;
    end
  end

`ifdef RDXBAR_OUT_SLICE_EN
  logic [DW-1:0] sPld [M][2];
  logic [SW-1:0] sSrc [M][2];
  logic [1:0]    sCnt [M];
  logic [M-1:0]  sHead;
  logic [M-1:0]  sPush;
  logic [M-1:0]  sPop;

  always_comb begin
    aRdy  = '0;
    sPush = '0;
    sPop  = '0;
    oVld  = '0;
    oPld  = '0;
    oSrc  = '0;
    for (int j = 0; j < M; j++) begin
      aRdy[j]  = (sCnt[j] != 2'd2);
      sPush[j] = aVld[j] && aRdy[j];
      sPop[j]  = (sCnt[j] != 2'd0) && oRdy[j];
      oVld[j]  = (sCnt[j] != 2'd0);
      oPld[j*DW +: DW] = sPld[j][sHead[j]];
      oSrc[j*SW +: SW] = sSrc[j][sHead[j]];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int j = 0; j < M; j++) begin
        sPld[j][0] <= '0;
        sPld[j][1] <= '0;
        sSrc[j][0] <= '0;
        sSrc[j][1] <= '0;
        sCnt[j]    <= 2'd0;
      end
      sHead <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        if (sPush[j]) begin
          sPld[j][sHead[j] ^ (sCnt[j] != 2'd0)] <= aPld[j];
          sSrc[j][sHead[j] ^ (sCnt[j] != 2'd0)] <= gnt[j];
        end
        if (sPop[j]) sHead[j] <= ~sHead[j];
        sCnt[j] <= sCnt[j] + {1'b0, sPush[j]} - {1'b0, sPop[j]};
      end
    end
  end
`else
  always_comb begin
    aRdy = oRdy;
    oVld = aVld;
    oPld = '0;
    oSrc = '0;
    for (int j = 0; j < M; j++) begin
      if (gHas[j]) begin
        oPld[j*DW +: DW] = aPld[j];
        oSrc[j*SW +: SW] = gnt[j];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rd_data_xbar_nxm.sv
// Directed bench for rd_data_xbar_nxm (N=16, M=12): output beats are matched against an expected queue.
module tb_rd_data_xbar_nxm;
  localparam int DW = 13;
  localparam int N  = 16;
  localparam int M  = 12;
  localparam int AW = 4;
  localparam int SW = 4;
  localparam int W  = 4 + SW + DW;

  logic          iClk;
  logic          iRst_n;
  logic [N-1:0]    iVld;
  logic [N*DW-1:0] iPld;
  logic [N*AW-1:0] iDst;
  logic [N-1:0]    iRdy;
  logic [M-1:0]    oVld;
  logic [M*DW-1:0] oPld;
  logic [M*SW-1:0] oSrc;
  logic [M-1:0]    oRdy;
  logic          oErr;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_w;
  logic [W-1:0] exp_w;
  int vecs = 0;
  int errs = 0;
  int order [6] = '{2, 5, 9, 2, 5, 9};

  rd_data_xbar_nxm #(.DW(DW), .N(N), .M(M), .AW(AW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iVld(iVld), .iPld(iPld), .iDst(iDst), .iRdy(iRdy),
    .oVld(oVld), .oPld(oPld), .oSrc(oSrc), .oRdy(oRdy), .oErr(oErr)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // driver tasks
  task automatic drv(input int i, input logic v, input logic last, input logic [11:0] d,
                     input logic [AW-1:0] dst);
    iVld[i] = v;
    iPld[i*DW +: DW] = {last, d};
    iDst[i*AW +: AW] = dst;
  endtask

  function automatic logic [W-1:0] mk(input int o, input int s, input logic last, input logic [11:0] d);
    logic [3:0] ob;
    logic [SW-1:0] sb;
    ob = 4'(o);
    sb = SW'(s);
    return {ob, sb, last, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // scoreboard: every accepted output beat must match the head of the expected queue
  always @(negedge iClk) begin
    for (int j = 0; j < M; j++) begin
      if (oVld[j] && oRdy[j]) begin
        got_w = {4'(j), oSrc[j*SW +: SW], oPld[j*DW +: DW]};
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $error("FAIL beat_unexpected: observed %0h expected none", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          assert (got_w === exp_w) else begin
            errs++;
            $error("FAIL beat: observed %0h expected %0h", got_w, exp_w);
          end
        end
      end
    end
  end

  initial begin
    iVld = '0; iPld = '0; iDst = '0; oRdy = '1; iRst_n = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_oVld", 64'(oVld), 64'(0));
    chk("rst_oPld", 64'(oPld), 64'(0));
    chk("rst_oSrc", 64'(oSrc), 64'(0));
    chk("rst_oErr", 64'(oErr), 64'(0));
    chk("rst_iRdy", 64'(iRdy), 64'(0));
    iRst_n = 1'b1;

    // single-beat packet in0 -> out3, same-cycle visibility
    step();
    drv(0, 1'b1, 1'b1, 12'h0AA, 4'd3);
    exp_q.push_back(mk(3, 0, 1'b1, 12'h0AA));
    @(negedge iClk);
    chk("s1_oVld3", 64'(oVld[3]), 64'(1));
    chk("s1_oPld3", 64'(oPld[3*DW +: DW]), 64'(13'h10AA));
    chk("s1_oSrc3", 64'(oSrc[3*SW +: SW]), 64'(0));
    chk("s1_iRdy0", 64'(iRdy[0]), 64'(1));
    step();
    drv(0, 1'b0, 1'b0, 12'h000, 4'd0);

    // round robin 2,5,9 on out0 with no gaps
    drv(2, 1'b1, 1'b1, 12'h102, 4'd0);
    drv(5, 1'b1, 1'b1, 12'h105, 4'd0);
    drv(9, 1'b1, 1'b1, 12'h109, 4'd0);
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(mk(0, order[c], 1'b1, 12'(12'h100 + order[c])));
      @(negedge iClk);
      chk("s2_iRdy", 64'(iRdy), 64'(16'(1 << order[c])));
      step();
    end
    drv(2, 1'b0, 1'b0, 12'h000, 4'd0);
    drv(5, 1'b0, 1'b0, 12'h000, 4'd0);
    drv(9, 1'b0, 1'b0, 12'h000, 4'd0);

    // 4-beat packet in1 -> out7, in4 joins from beat 2
    for (int b = 0; b < 4; b++) begin
      drv(1, 1'b1, b == 3, 12'(12'h700 + b), 4'd7);
      if (b == 1) drv(4, 1'b1, 1'b1, 12'h444, 4'd7);
      exp_q.push_back(mk(7, 1, b == 3, 12'(12'h700 + b)));
      @(negedge iClk);
      chk("s3_iRdy1", 64'(iRdy[1]), 64'(1));
      if (b >= 1) chk("s3_iRdy4_wait", 64'(iRdy[4]), 64'(0));
      step();
    end
    drv(1, 1'b0, 1'b0, 12'h000, 4'd0);
    exp_q.push_back(mk(7, 4, 1'b1, 12'h444));
    @(negedge iClk);
    chk("s3_iRdy4_go", 64'(iRdy[4]), 64'(1));
    step();
    drv(4, 1'b0, 1'b0, 12'h000, 4'd0);

    // backpressure on out2: in3 holds the output, in6 waits
    oRdy[2] = 1'b0;
    drv(3, 1'b1, 1'b1, 12'h333, 4'd2);
    drv(6, 1'b1, 1'b1, 12'h666, 4'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      chk("s4_oVld2", 64'(oVld[2]), 64'(1));
      chk("s4_oSrc2", 64'(oSrc[2*SW +: SW]), 64'(3));
      chk("s4_oPld2", 64'(oPld[2*DW +: DW]), 64'(13'h1333));
      chk("s4_iRdy6", 64'(iRdy[6]), 64'(0));
      chk("s4_iRdy3", 64'(iRdy[3]), 64'(0));
      step();
    end
    oRdy[2] = 1'b1;
    exp_q.push_back(mk(2, 3, 1'b1, 12'h333));
    @(negedge iClk);
    chk("s4_iRdy3_go", 64'(iRdy[3]), 64'(1));
    step();
    drv(3, 1'b0, 1'b0, 12'h000, 4'd0);
    exp_q.push_back(mk(2, 6, 1'b1, 12'h666));
    @(negedge iClk);
    chk("s4_oSrc2_next", 64'(oSrc[2*SW +: SW]), 64'(6));
    step();
    drv(6, 1'b0, 1'b0, 12'h000, 4'd0);

    // out-of-range destinations 13 and 12 (== M)
    drv(0, 1'b1, 1'b1, 12'h055, 4'd13);
    @(negedge iClk);
    chk("s5_iRdy0_13", 64'(iRdy[0]), 64'(1));
    chk("s5_oVld_13", 64'(oVld), 64'(0));
    chk("s5_oErr_pre", 64'(oErr), 64'(0));
    step();
    drv(0, 1'b1, 1'b1, 12'h056, 4'd12);
    @(negedge iClk);
    chk("s5_iRdy0_12", 64'(iRdy[0]), 64'(1));
    chk("s5_oVld_12", 64'(oVld), 64'(0));
    chk("s5_oErr_set", 64'(oErr), 64'(1));
    step();
    drv(0, 1'b0, 1'b0, 12'h000, 4'd0);
    repeat (3) step();
    @(negedge iClk);
    chk("s5_oErr_sticky", 64'(oErr), 64'(1));
    step();

    // reset mid-packet in8 -> out5, then fresh grant to in0
    for (int b = 0; b < 2; b++) begin
      drv(8, 1'b1, 1'b0, 12'(12'h800 + b), 4'd5);
      exp_q.push_back(mk(5, 8, 1'b0, 12'(12'h800 + b)));
      @(negedge iClk);
      chk("s6_oSrc5", 64'(oSrc[5*SW +: SW]), 64'(8));
      step();
    end
    drv(8, 1'b1, 1'b0, 12'h802, 4'd5);
    #2 iRst_n = 1'b0;
    #1;
    chk("s6_rst_oVld", 64'(oVld), 64'(0));
    chk("s6_rst_oPld", 64'(oPld), 64'(0));
    chk("s6_rst_oSrc", 64'(oSrc), 64'(0));
    chk("s6_rst_oErr", 64'(oErr), 64'(0));
    chk("s6_rst_iRdy", 64'(iRdy), 64'(0));
    @(negedge iClk);
    drv(8, 1'b0, 1'b0, 12'h000, 4'd0);
    step();
    iRst_n = 1'b1;
    drv(0, 1'b1, 1'b1, 12'h0F0, 4'd5);
    exp_q.push_back(mk(5, 0, 1'b1, 12'h0F0));
    @(negedge iClk);
    chk("s6_oVld5", 64'(oVld[5]), 64'(1));
    chk("s6_oSrc5_new", 64'(oSrc[5*SW +: SW]), 64'(0));
    chk("s6_iRdy0", 64'(iRdy[0]), 64'(1));
    step();
    drv(0, 1'b0, 1'b0, 12'h000, 4'd0);

    step();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
